// File: rtl/pe_vec_seq.sv
// Vector dot-product sequencer: walks an operand buffer, feeds one PE MAC core
// element by element and returns the accumulated sum on a valid/ready port.
module pe_vec_seq #(
  parameter int LEN_W   = 6,
  parameter int BUF_AW  = 6,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [BUF_AW-1:0] cmd_base,
  input  logic              cmd_mode,
  output logic              buf_re,
  output logic [BUF_AW-1:0] buf_addr,
  input  logic [15:0]       buf_rdata,
  output logic              pe_clear,
  output logic              pe_start,
  output logic              pe_mode,
  output logic [7:0]        pe_a,
  output logic [7:0]        pe_b,
  input  logic              pe_out_vld,
  input  logic [23:0]       pe_sum,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [23:0]       res_data,
  output logic              res_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam int SUM_W = (LEN_W > BUF_AW) ? LEN_W : BUF_AW;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_LOAD, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [BUF_AW-1:0] base_q, base_d;
  logic              mode_q, mode_d;
  logic [CNT_W-1:0]  waitCnt_q, waitCnt_d;
  logic [23:0]       resData_q, resData_d;
  logic              resErr_q, resErr_d;
  logic [7:0]        peA_q, peA_d;
  logic [7:0]        peB_q, peB_d;
  logic [SUM_W-1:0]  addrWide;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    base_d    = base_q;
    mode_d    = mode_q;
    waitCnt_d = waitCnt_q;
    resData_d = resData_q;
    resErr_d  = resErr_q;
    peA_d     = peA_q;
    peB_d     = peB_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          len_d     = cmd_len;
          base_d    = cmd_base;
          mode_d    = cmd_mode;
          idx_d     = '0;
          resData_d = '0;
          resErr_d  = 1'b0;
          state_d   = (cmd_len == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        peA_d   = buf_rdata[7:0];
        peB_d   = buf_rdata[15:8];
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        waitCnt_d = '0;
        state_d   = S_WAIT;
      end
      // A response arriving on the last timeout cycle still counts as success.
      S_WAIT: begin
        if (pe_out_vld) begin
          resData_d = pe_sum;
          if (idx_q == len_q - LEN_W'(1)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + LEN_W'(1);
            state_d = S_FETCH;
          end
        end else if (waitCnt_q == CNT_W'(TIMEOUT - 1)) begin
          resErr_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          waitCnt_d = waitCnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      base_q    <= '0;
      mode_q    <= 1'b0;
      waitCnt_q <= '0;
      resData_q <= '0;
      resErr_q  <= 1'b0;
      peA_q     <= '0;
      peB_q     <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      base_q    <= base_d;
      mode_q    <= mode_d;
      waitCnt_q <= waitCnt_d;
      resData_q <= resData_d;
      resErr_q  <= resErr_d;
      peA_q     <= peA_d;
      peB_q     <= peB_d;
    end
  end

  // Strobes are masked during reset so an aborted job emits no stray pulse.
  assign addrWide  = SUM_W'(base_q) + SUM_W'(idx_q);
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign pe_clear  = (state_q == S_CLEAR) && !reset;
  assign buf_re    = (state_q == S_FETCH) && !reset;
  assign pe_start  = (state_q == S_ISSUE) && !reset;
  assign buf_addr  = (state_q == S_FETCH) ? addrWide[BUF_AW-1:0] : '0;
  assign pe_mode   = mode_q;
  assign pe_a      = peA_q;
  assign pe_b      = peB_q;
  assign res_data  = resData_q;
  assign res_err   = resErr_q;

endmodule

// File: tb/tb_pe_vec_seq.sv
// Randomized self-checking bench for pe_vec_seq with a behavioural operand
// buffer, a latency-programmable PE MAC model and a job-level reference model.
module tb_pe_vec_seq;
  localparam int LEN_W     = 6;
  localparam int BUF_AW    = 6;
  localparam int TIMEOUT   = 16;
  localparam int BUF_WORDS = 1 << BUF_AW;
  localparam int BUDGET    = 2000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [BUF_AW-1:0] cmd_base = '0;
  logic              cmd_mode = 1'b0;
  logic              buf_re;
  logic [BUF_AW-1:0] buf_addr;
  logic [15:0]       buf_rdata = '0;
  logic              pe_clear, pe_start, pe_mode;
  logic [7:0]        pe_a, pe_b;
  logic              pe_out_vld;
  logic [23:0]       pe_sum;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [23:0]       res_data;
  logic              res_err, busy;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pe_vec_seq #(.LEN_W(LEN_W), .BUF_AW(BUF_AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_base(cmd_base), .cmd_mode(cmd_mode),
    .buf_re(buf_re), .buf_addr(buf_addr), .buf_rdata(buf_rdata),
    .pe_clear(pe_clear), .pe_start(pe_start), .pe_mode(pe_mode),
    .pe_a(pe_a), .pe_b(pe_b), .pe_out_vld(pe_out_vld), .pe_sum(pe_sum),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .busy(busy)
  );

  // Operand buffer with one-cycle read latency
  logic [15:0] mem [BUF_WORDS];
  always @(posedge clk) if (buf_re) buf_rdata <= mem[buf_addr];

  // PE model: accumulates b*a on each start, answers after latArr[i] cycles (0 = never)
  int          latArr [64];
  int          startIdx = 0;
  int          pendCnt = 0;
  int          peAcc = 0;
  logic        modelVld = 1'b0;
  logic [23:0] modelSum = '0;
  logic        strayVld = 1'b0;
  assign pe_out_vld = modelVld | strayVld;
  assign pe_sum     = strayVld ? 24'h123456 : modelSum;

  always @(posedge clk) begin
    modelVld <= 1'b0;
    if (reset) begin
      peAcc = 0; pendCnt = 0; startIdx = 0;
      modelSum <= '0;
    end else if (pe_clear) begin
      peAcc = 0; pendCnt = 0; startIdx = 0;
    end else begin
      if (pe_start) begin
        peAcc = peAcc + int'($signed(pe_b)) * int'(pe_a);
        pendCnt = (startIdx < 64) ? latArr[startIdx] : 1;
        startIdx++;
      end
      if (pendCnt == 1) begin
        modelVld <= 1'b1;
        modelSum <= peAcc[23:0];
        pendCnt = 0;
      end else if (pendCnt > 1) begin
        pendCnt--;
      end
    end
  end

  // Monitor: records strobes and operands away from the clock edge
  int          clrCnt = 0;
  logic [BUF_AW-1:0] addrQ [$];
  logic [15:0] opQ [$];
  always @(negedge clk) begin
    if (pe_clear) clrCnt++;
    if (buf_re) addrQ.push_back(buf_addr);
    if (pe_start) opQ.push_back({pe_b, pe_a});
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyReset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs one job; called at a negedge with the DUT idle and latArr preloaded
  task automatic applyStimulus(input int len, input int base, input bit mode,
                               input int holdCycles);
    int          acc, expStarts, expCycles, cyc, pb, pa;
    bit          expErr;
    logic [23:0] expData;
    logic [15:0] w;
    acc = 0; expStarts = 0; expErr = 1'b0; expData = '0;
    expCycles = (len > 0) ? 1 : 0;
    for (int i = 0; i < len; i++) begin
      w  = mem[(base + i) % BUF_WORDS];
      pb = int'($signed(w[15:8]));
      pa = int'(w[7:0]);
      acc += pb * pa;
      expStarts++;
      if (latArr[i] == 0 || latArr[i] > TIMEOUT) begin
        expErr = 1'b1;
        expCycles += 3 + TIMEOUT;
        break;
      end
      expData = acc[23:0];
      expCycles += 3 + latArr[i];
    end

    clrCnt = 0;
    addrQ.delete();
    opQ.delete();
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);
    cmd_base  = BUF_AW'(base);
    cmd_mode  = mode;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 0;
    while (!res_valid && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    if (!res_valid) begin
      checkOutput("resValidBound", 32'(res_valid), 32'd1);
      applyReset();
      return;
    end

    checkOutput("latency", cyc, expCycles);
    checkOutput("resData", res_data, expData);
    checkOutput("resErr", res_err, expErr);
    checkOutput("peMode", pe_mode, mode);
    checkOutput("clearCount", clrCnt, (len > 0) ? 1 : 0);
    checkOutput("startCount", opQ.size(), expStarts);
    checkOutput("fetchCount", addrQ.size(), expStarts);
    for (int i = 0; i < expStarts && i < addrQ.size() && i < opQ.size(); i++) begin
      checkOutput("bufAddr", addrQ[i], (base + i) % BUF_WORDS);
      checkOutput("operands", opQ[i], mem[(base + i) % BUF_WORDS]);
    end

    cmd_valid = 1'b1;
    cmd_len   = LEN_W'($urandom_range(1, 7));
    repeat (holdCycles) begin
      @(negedge clk);
      checkOutput("holdValid", {res_valid, cmd_ready, busy}, 3'b101);
      checkOutput("holdData", res_data, expData);
    end
    cmd_valid = 1'b0;
    checkOutput("holdNoNewJob", opQ.size() + clrCnt, expStarts + ((len > 0) ? 1 : 0));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checkOutput("idleAfterPop", {res_valid, cmd_ready, busy}, 3'b010);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int len, base, r;
    for (int i = 0; i < BUF_WORDS; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 64; i++) latArr[i] = 1;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("resetHandshake", {cmd_ready, busy, res_valid, res_err}, 4'b1000);
    checkOutput("resetStrobes", {pe_clear, pe_start, buf_re}, 3'b000);
    checkOutput("resetData", res_data, 24'd0);
    checkOutput("resetOperands", {pe_mode, pe_a, pe_b, buf_addr}, 32'd0);

    $display("[TB] directed: three-element dot product");
    mem[0] = {8'd4, 8'd1};
    mem[1] = {8'hFB, 8'd2};
    mem[2] = {8'd6, 8'd3};
    applyStimulus(3, 0, 1'b0, 0);
    checkOutput("tc1Sum", res_data, 24'd12);

    $display("[TB] directed: address wrap");
    for (int i = 0; i < 4; i++) latArr[i] = $urandom_range(1, 3);
    applyStimulus(4, 62, 1'b1, 1);

    $display("[TB] directed: zero length");
    applyStimulus(0, 5, 1'b0, 2);

    $display("[TB] directed: unresponsive PE");
    for (int i = 0; i < 4; i++) latArr[i] = 0;
    applyStimulus(2, 10, 1'b1, 0);

    $display("[TB] directed: held result");
    for (int i = 0; i < 4; i++) latArr[i] = 2;
    applyStimulus(3, 20, 1'b0, 5);

    $display("[TB] directed: response on last timeout cycle and one cycle late");
    latArr[0] = TIMEOUT; latArr[1] = 1; latArr[2] = TIMEOUT + 1;
    applyStimulus(3, 30, 1'b1, 0);
    latArr[0] = 1; latArr[1] = TIMEOUT;
    applyStimulus(2, 40, 1'b0, 1);

    $display("[TB] randomized jobs");
    for (int j = 0; j < 25; j++) begin
      for (int i = 0; i < 64; i++) begin
        r = $urandom_range(0, 19);
        latArr[i] = (r == 0) ? 0 : (r == 1) ? TIMEOUT + 1 : (r == 2) ? TIMEOUT
                  : $urandom_range(1, 4);
      end
      len  = $urandom_range(0, 8);
      base = $urandom_range(0, BUF_WORDS - 1);
      applyStimulus(len, base, 1'($urandom), $urandom_range(0, 3));
    end

    $display("[TB] directed: reset mid-job");
    foreach (latArr[i]) latArr[i] = 0;
    for (int v = 0; v < 3; v++) begin
      cmd_valid = 1'b1;
      cmd_len   = LEN_W'(5);
      cmd_base  = BUF_AW'($urandom);
      cmd_mode  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat ((v == 0) ? 5 : (v == 1) ? 3 : 1) @(negedge clk);
      checkOutput("midJobBusy", busy, 1'b1);
      reset = 1'b1;
      #1;
      checkOutput("resetCycleStrobes", {pe_clear, pe_start, buf_re}, 3'b000);
      @(negedge clk);
      reset = 1'b0;
      checkOutput("postResetHandshake", {cmd_ready, busy, res_valid, res_err}, 4'b1000);
      checkOutput("postResetStrobes", {pe_clear, pe_start, buf_re}, 3'b000);
      checkOutput("postResetOperands", {pe_mode, pe_a, pe_b, buf_addr}, 32'd0);
      strayVld = 1'b1;
      @(negedge clk);
      strayVld = 1'b0;
      checkOutput("strayVldIgnored", res_data, 24'd0);
      checkOutput("strayVldIdle", {cmd_ready, busy, res_valid}, 3'b100);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
